// File: rtl/decoder_nto2n_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared types for the registered N-to-2**N decoder.
//   mode_e  : encoding of the 2-bit mode input
//   state_e : control FSM states (IDLE / DIRECT / SCAN)
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_nto2n_seq_core.sv
// -----------------------------------------------------------------------------
// decoder_core
//   Purely combinational index decoder.
//   idx    : IN_W-bit index
//   thermo : 0 -> one-hot (bit idx only), 1 -> thermometer (bits 0..idx)
//   dec    : 2**IN_W-bit decoded vector
// -----------------------------------------------------------------------------
module decoder_core #(
  parameter int unsigned IN_W = 3
) (
  input  logic [IN_W-1:0]      idx,
  input  logic                 thermo,
  output logic [(2**IN_W)-1:0] dec
);

  localparam int unsigned OUT_W = 2**IN_W;

  logic [31:0] w_idx32;

  assign w_idx32 = 32'(idx);

  always_comb begin
    dec = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      if (thermo) begin
        dec[k] = (k <= w_idx32);
      end else begin
        dec[k] = (k == w_idx32);
      end
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// -----------------------------------------------------------------------------
// decoder_nto2n_seq
//   Registered N-to-2**N decoder with one-hot, thermometer and self-timed
//   scan modes. All outputs are registered (latency 1 from sampled inputs).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : block enable, low forces outputs to zero
//   mode      : 00 one-hot, 01 thermometer, 10 scan, 11 reserved
//   in        : decode index (direct modes) / start index (scan entry)
//   dwell     : scan cycles per position minus one
//   out       : registered decode result
//   out_valid : out carries a valid decode
//   scan_wrap : one-cycle pulse when the scan index wraps OUT_W-1 -> 0
//   mode_err  : reserved mode requested while enabled
// -----------------------------------------------------------------------------
module decoder_nto2n_seq #(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned OUT_W   = 2**IN_W,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [IN_W-1:0]    in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               scan_wrap,
  output logic               mode_err
);

  import decoder_pkg::*;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IN_W-1:0]    r_idx;
  logic [IN_W-1:0]    w_idx_nxt;
  logic [IN_W-1:0]    w_idx_inc;
  logic [IN_W-1:0]    w_dec_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   w_out_nxt;
  logic [OUT_W-1:0]   w_dec;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               r_err;
  logic               w_err_nxt;
  mode_e              w_mode;
  logic               w_thermo;
  logic               w_scan_hold;
  logic               w_scan_step;

  assign w_mode    = mode_e'(mode);
  assign w_thermo  = (w_mode == MODE_THERMO);
  assign w_idx_inc = r_idx + IN_W'(1);

  // Already scanning and asked to keep scanning: idx/cnt run on their own.
  // Any other way into SCAN is an entry that restarts from `in`.
  assign w_scan_hold = (r_state == SCAN) && en && (w_mode == MODE_SCAN);
  assign w_scan_step = w_scan_hold && (r_cnt == '0);

  // The decoder is fed the index the output will show after this edge, so
  // the registered output never lags the scan index.
  assign w_dec_idx = w_scan_hold ? (w_scan_step ? w_idx_inc : r_idx) : in;

  decoder_core #(
    .IN_W (IN_W)
  ) u_core (
    .idx    (w_dec_idx),
    .thermo (w_thermo),
    .dec    (w_dec)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: the target depends only on en/mode, from any state
  always_comb begin
    w_state_nxt = IDLE;
    if (en) begin
      unique case (w_mode)
        MODE_ONEHOT, MODE_THERMO: w_state_nxt = DIRECT;
        MODE_SCAN:                w_state_nxt = SCAN;
        default:                  w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (w_state_nxt)
      DIRECT: begin
        w_out_nxt   = w_dec;
        w_valid_nxt = 1'b1;
      end
      SCAN: begin
        w_out_nxt   = w_dec;
        w_valid_nxt = 1'b1;
        if (w_scan_hold) begin
          if (w_scan_step) begin
            w_idx_nxt  = w_idx_inc;
            w_cnt_nxt  = dwell;
            w_wrap_nxt = (w_idx_inc == '0);
          end else begin
            w_cnt_nxt = r_cnt - DWELL_W'(1);
          end
        end else begin
          w_idx_nxt = in;
          w_cnt_nxt = dwell;
        end
      end
      default: begin
        w_err_nxt = en && (w_mode == MODE_RSVD);
      end
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign scan_wrap = r_wrap;
  assign mode_err  = r_err;

endmodule
